// File: rtl/dot_product_sequencer.sv
// Phase sequencer for the dot-product memory subsystem: clear, load, compute, write-back.
// Drives controller mode/reset strobes, watches its status counters, and guards each phase with a watchdog.
module dot_product_sequencer #(
  parameter int Addr_Width           = 4,
  parameter int Nums_Data_in_bits    = 4,
  parameter int Nums_Pipeline_Stages = 4,
  parameter int Timeout_Cycles       = 64,
  parameter int WD_Width             = $clog2(Timeout_Cycles + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       skip_load,
  input  logic                       abort,
  input  logic [Addr_Width:0]        mem_index_status,
  input  logic [Nums_Data_in_bits:0] step_status,
  output logic                       Mem_reset,
  output logic                       Comp_reset,
  output logic                       Mem_Index_reset,
  output logic                       load_from_file,
  output logic                       Computing,
  output logic                       write_to_file,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 phase
);

  localparam int Ram_Depth               = 1 << Addr_Width;
  localparam int Nums_Data               = 1 << Nums_Data_in_bits;
  localparam int Total_Computation_Steps = Nums_Data + Nums_Pipeline_Stages - 1;

  localparam logic [31:0] LP_LOAD_DONE  = 32'(Ram_Depth);
  localparam logic [31:0] LP_WRITE_DONE = 32'(Ram_Depth + 1);
  localparam logic [31:0] LP_STEPS_DONE = 32'(Total_Computation_Steps);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  logic [2:0]          r_state;
  logic                r_skip;
  logic [WD_Width-1:0] r_wd;

  logic [2:0] w_next;
  logic       w_rst_all;
  logic       w_load_entry;
  logic       w_comp_entry;
  logic       w_write_entry;
  logic       w_done;
  logic       w_qual;
  logic       w_expired;
  logic       w_in_phase;
  logic       w_accept;

  // Status is masked for the first two cycles of a phase so the previous phase's counters cannot end it early.
  assign w_qual     = (r_wd >= WD_Width'(2));
  assign w_expired  = (r_wd == WD_Width'(Timeout_Cycles));
  assign w_in_phase = (r_state == S_LOAD) || (r_state == S_COMPUTE) || (r_state == S_WRITE);
  assign w_accept   = (r_state == S_IDLE) && start && !abort;

  always_comb begin
    w_next        = r_state;
    w_rst_all     = 1'b0;
    w_load_entry  = 1'b0;
    w_comp_entry  = 1'b0;
    w_write_entry = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next    = S_CLEAR;
          w_rst_all = 1'b1;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          w_next    = S_IDLE;
          w_rst_all = 1'b1;
        end else if (r_skip) begin
          w_next       = S_COMPUTE;
          w_comp_entry = 1'b1;
        end else begin
          w_next       = S_LOAD;
          w_load_entry = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_next    = S_IDLE;
          w_rst_all = 1'b1;
        end else if (w_qual && (32'(mem_index_status) >= LP_LOAD_DONE)) begin
          w_next       = S_COMPUTE;
          w_comp_entry = 1'b1;
        end else if (w_expired) begin
          w_next    = S_ERROR;
          w_rst_all = 1'b1;
        end
      end
      S_COMPUTE: begin
        if (abort) begin
          w_next    = S_IDLE;
          w_rst_all = 1'b1;
        end else if (w_qual && (32'(step_status) >= LP_STEPS_DONE)) begin
          w_next        = S_WRITE;
          w_write_entry = 1'b1;
        end else if (w_expired) begin
          w_next    = S_ERROR;
          w_rst_all = 1'b1;
        end
      end
      S_WRITE: begin
        if (abort) begin
          w_next    = S_IDLE;
          w_rst_all = 1'b1;
        end else if (w_qual && (32'(mem_index_status) >= LP_WRITE_DONE)) begin
          w_next = S_DONE;
          w_done = 1'b1;
        end else if (w_expired) begin
          w_next    = S_ERROR;
          w_rst_all = 1'b1;
        end
      end
      S_DONE: begin
        w_next    = S_IDLE;
        w_rst_all = abort;
      end
      S_ERROR: begin
        if (abort) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_skip          <= 1'b0;
      r_wd            <= '0;
      Mem_reset       <= 1'b0;
      Comp_reset      <= 1'b0;
      Mem_Index_reset <= 1'b0;
      load_from_file  <= 1'b0;
      Computing       <= 1'b0;
      write_to_file   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_skip <= skip_load;
      // Any state change restarts the watchdog; it only counts while a phase persists.
      if (w_next != r_state)
        r_wd <= '0;
      else if (w_in_phase && !w_expired)
        r_wd <= r_wd + WD_Width'(1);
      Mem_reset       <= w_rst_all;
      Comp_reset      <= w_rst_all | w_comp_entry;
      Mem_Index_reset <= w_rst_all | w_write_entry;
      load_from_file  <= w_load_entry;
      Computing       <= w_comp_entry;
      write_to_file   <= w_write_entry;
      busy            <= (w_next != S_IDLE);
      done            <= w_done;
      error           <= (w_next == S_ERROR);
    end
  end

  assign phase = r_state;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: a cycle vector table plus hand-written multi-cycle runs
// against a small memory-controller model that reacts to the mode strobes one cycle late.
module tb_dot_product_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       skip_load = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] mem_index_status;
  logic [4:0] step_status;
  logic       Mem_reset, Comp_reset, Mem_Index_reset;
  logic       load_from_file, Computing, write_to_file;
  logic       busy, done, error;
  logic [2:0] phase;

  always #5 clk = ~clk;

  dot_product_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .skip_load(skip_load), .abort(abort),
    .mem_index_status(mem_index_status), .step_status(step_status),
    .Mem_reset(Mem_reset), .Comp_reset(Comp_reset), .Mem_Index_reset(Mem_Index_reset),
    .load_from_file(load_from_file), .Computing(Computing), .write_to_file(write_to_file),
    .busy(busy), .done(done), .error(error), .phase(phase)
  );

  // Controller model: strobes are registered once, then restart the matching counter.
  logic       use_model = 1'b0;
  logic       freeze = 1'b0;
  logic [4:0] tb_idx = 5'd0;
  logic [4:0] tb_step = 5'd0;
  logic [4:0] m_idx, m_step;
  logic [1:0] m_mode;
  logic       d_load, d_comp, d_write;

  assign mem_index_status = use_model ? (freeze ? 5'd5 : m_idx) : tb_idx;
  assign step_status      = use_model ? m_step : tb_step;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_idx <= 5'd0; m_step <= 5'd0; m_mode <= 2'd0;
      d_load <= 1'b0; d_comp <= 1'b0; d_write <= 1'b0;
    end else begin
      d_load  <= load_from_file;
      d_comp  <= Computing;
      d_write <= write_to_file;
      if (d_load) begin
        m_mode <= 2'd1; m_idx <= 5'd0;
      end else if (d_comp) begin
        m_mode <= 2'd2; m_step <= 5'd0;
      end else if (d_write) begin
        m_mode <= 2'd3; m_idx <= 5'd0;
      end else begin
        case (m_mode)
          2'd1: if (m_idx < 5'd16) m_idx <= m_idx + 5'd1;
          2'd2: if (m_step < 5'd19) m_step <= m_step + 5'd1;
          2'd3: if (m_idx < 5'd17) m_idx <= m_idx + 5'd1;
          default: ;
        endcase
      end
    end
  end

  // Monitor of strobe pulses and phase sequence
  logic       mon_en = 1'b0;
  int         cyc = 0;
  int         n_load, n_comp, n_write, n_done;
  int         t_load, t_comp, t_write;
  logic [2:0] plog[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en) begin
      if (load_from_file) begin n_load <= n_load + 1; t_load <= cyc; end
      if (Computing)      begin n_comp <= n_comp + 1; t_comp <= cyc; end
      if (write_to_file)  begin n_write <= n_write + 1; t_write <= cyc; end
      if (done) n_done <= n_done + 1;
      if (phase != plog[$]) plog.push_back(phase);
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {phase, Mem_reset, Comp_reset, Mem_Index_reset, load, Computing, write, busy, done, error}
  function automatic logic [11:0] outs();
    return {phase, Mem_reset, Comp_reset, Mem_Index_reset, load_from_file, Computing,
            write_to_file, busy, done, error};
  endfunction

  function automatic logic [23:0] pack_log();
    logic [23:0] r = '0;
    foreach (plog[i]) if (i < 8) r = {r[20:0], plog[i]};
    return r;
  endfunction

  task automatic mon_clear();
    n_load = 0; n_comp = 0; n_write = 0; n_done = 0;
    t_load = 0; t_comp = 0; t_write = 0;
    plog.delete();
    plog.push_back(phase);
  endtask

  task automatic run_start(input logic sk);
    start = 1'b1; skip_load = sk;
    tick();
    start = 1'b0; skip_load = 1'b0;
  endtask

  task automatic wait_phase(input string nm, input logic [2:0] p, input int budget, output int c);
    c = 0;
    while (phase != p && c < budget) begin
      tick();
      c++;
    end
    if (phase != p) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: phase %0d after %0d cycles, required %0d", nm, phase, c, p);
    end
  endtask

  typedef struct {
    logic        st;
    logic        sk;
    logic        ab;
    logic [4:0]  idx;
    logic [4:0]  stp;
    logic [11:0] exp;
  } vec_t;

  vec_t vt[17];

  initial begin
    int c;
    vt[0]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  {3'd0, 6'b000000, 3'b000}};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 5'd0,  5'd0,  {3'd0, 6'b000000, 3'b000}};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  {3'd1, 6'b111000, 3'b100}};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd19, {3'd3, 6'b010010, 3'b100}};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd19, {3'd3, 6'b000000, 3'b100}};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd19, {3'd3, 6'b000000, 3'b100}};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd19, {3'd4, 6'b001001, 3'b100}};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 5'd17, 5'd0,  {3'd4, 6'b000000, 3'b100}};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 5'd17, 5'd0,  {3'd4, 6'b000000, 3'b100}};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 5'd17, 5'd0,  {3'd5, 6'b000000, 3'b110}};
    vt[10] = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  {3'd0, 6'b000000, 3'b000}};
    vt[11] = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  {3'd1, 6'b111000, 3'b100}};
    vt[12] = '{1'b0, 1'b0, 1'b0, 5'd16, 5'd0,  {3'd2, 6'b000100, 3'b100}};
    vt[13] = '{1'b0, 1'b0, 1'b0, 5'd16, 5'd0,  {3'd2, 6'b000000, 3'b100}};
    vt[14] = '{1'b0, 1'b0, 1'b0, 5'd16, 5'd0,  {3'd2, 6'b000000, 3'b100}};
    vt[15] = '{1'b0, 1'b0, 1'b1, 5'd16, 5'd0,  {3'd0, 6'b111000, 3'b000}};
    vt[16] = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  {3'd0, 6'b000000, 3'b000}};

    // Reset state
    tick(); tick();
    chk("reset_outs", 32'(outs()), 32'd0);
    reset_n = 1'b1;

    // Table of single-cycle vectors
    for (int i = 0; i < 17; i++) begin
      start = vt[i].st; skip_load = vt[i].sk; abort = vt[i].ab;
      tb_idx = vt[i].idx; tb_step = vt[i].stp;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
    end
    start = 1'b0; skip_load = 1'b0; abort = 1'b0; tb_idx = 5'd0; tb_step = 5'd0;

    // Completion and watchdog expiry in the same cycle: completion wins
    run_start(1'b1);
    tick();
    chk("cmp_entry", 32'(phase), 32'd3);
    repeat (64) tick();
    chk("cmp_hold", 32'(phase), 32'd3);
    tb_step = 5'd19;
    tick();
    chk("cmp_vs_wd", 32'(phase), 32'd4);
    abort = 1'b1; tick(); abort = 1'b0;
    tb_step = 5'd0;
    chk("cmp_abort_idle", 32'(phase), 32'd0);

    // Full run with the controller model
    use_model = 1'b1;
    mon_clear();
    mon_en = 1'b1;
    run_start(1'b0);
    wait_phase("full_done", 3'd5, 200, c);
    tick();
    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("full_load_cnt", n_load, 1);
    chk("full_comp_cnt", n_comp, 1);
    chk("full_write_cnt", n_write, 1);
    chk("full_order", 32'((t_load < t_comp) && (t_comp < t_write)), 32'd1);
    chk("full_done_cnt", n_done, 1);
    chk("full_plog_len", plog.size(), 7);
    chk("full_plog", 32'(pack_log()), 32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0}));

    // Stale step status at COMPUTE entry
    run_start(1'b0);
    wait_phase("stale_enter", 3'd3, 100, c);
    chk("stale_pre", 32'(step_status), 32'd19);
    tick();
    chk("stale_wd1", 32'(phase), 32'd3);
    tick();
    chk("stale_wd2", 32'(phase), 32'd3);
    wait_phase("stale_write", 3'd4, 100, c);
    chk("stale_exit_cycles", c, 20);
    wait_phase("stale_done", 3'd5, 100, c);
    tick();

    // skip_load run
    mon_clear();
    mon_en = 1'b1;
    run_start(1'b1);
    wait_phase("skip_done", 3'd5, 200, c);
    tick();
    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("skip_load_cnt", n_load, 0);
    chk("skip_done_cnt", n_done, 1);
    chk("skip_plog", 32'(pack_log()), 32'({3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd0}));

    // Stalled controller in LOAD
    freeze = 1'b1;
    run_start(1'b0);
    tick();
    chk("stall_load", 32'(phase), 32'd2);
    wait_phase("stall_err", 3'd6, 100, c);
    chk("stall_cycles", c, 65);
    chk("stall_err_entry", 32'(outs()), 32'({3'd6, 6'b111000, 3'b101}));
    start = 1'b1; tick(); start = 1'b0;
    chk("stall_err_hold", 32'(outs()), 32'({3'd6, 6'b000000, 3'b101}));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("stall_abort", 32'(outs()), 32'({3'd0, 6'b000000, 3'b000}));
    freeze = 1'b0;

    // Abort in COMPUTE, then an immediate full run
    run_start(1'b0);
    wait_phase("abort_enter", 3'd3, 100, c);
    repeat (7) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_cmp", 32'(outs()), 32'({3'd0, 6'b111000, 3'b000}));
    tick();
    chk("abort_quiet", 32'(outs()), 32'({3'd0, 6'b000000, 3'b000}));
    mon_clear();
    mon_en = 1'b1;
    run_start(1'b0);
    wait_phase("rerun_done", 3'd5, 200, c);
    tick();
    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("rerun_done_cnt", n_done, 1);
    chk("rerun_idle", 32'(phase), 32'd0);

    // Asynchronous reset in the middle of WRITE
    run_start(1'b0);
    wait_phase("arst_write", 3'd4, 200, c);
    #2 reset_n = 1'b0;
    #1 chk("arst_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arst_restart", 32'(outs()), 32'({3'd1, 6'b111000, 3'b100}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
